mdr_align_unit: RTL and testbench

Parametrised load/store alignment unit between the core's memory stage and the word-wide data bus. Generalises single-byte, zero-extended extraction from the memory data register to byte, halfword, word and doubleword accesses with sign or zero extension, store lane placement with byte enables, and misaligned accesses split into two bus beats. Sits between the core's load/store request port and the data memory/bus master. Uses a valid/ready handshake on all three sides.

---
 rtl/mdr_align_unit_if.sv | 47 ++++
 rtl/mdr_align_unit.sv | 163 ++++++++++++++++
 tb/tb_mdr_align_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mdr_align_unit_if.sv
// Bus bundle for mdr_align_unit: request, memory beat and response channels.
// slave = alignment unit side, master = core/bus-model side.
interface mdr_align_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int BYTES = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BYTES-1:0]  mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready
    );
endinterface

// File: rtl/mdr_align_unit.sv
// Load/store alignment unit: lane placement, extension, two-beat split.
// Ports: clk, rst_n (sync, active low), bus (mdr_align_unit_if.slave).
module mdr_align_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    mdr_align_unit_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t              state;
    logic                we_q;
    logic [1:0]          size_q;
    logic                sgn_q;
    logic [OFF_W-1:0]    off_q;
    logic                cross_q;
    logic [2*BYTES-1:0]  mask_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   lo_q;

    logic [OFF_W-1:0]    off_in;
    int                  nb_in;
    logic                err_in;
    logic                cross_in;
    logic [2*BYTES-1:0]  mask_in;
    logic [2*BYTES-1:0]  be_lo_w;
    logic [2*BYTES-1:0]  be_hi_w;

    // Shift the two-beat window down to the access, then extend above nbytes.
    function automatic logic [DATA_W-1:0] extract(
        input logic [2*DATA_W-1:0] cat,
        input logic [OFF_W-1:0]    off,
        input logic [1:0]          size,
        input logic                sgn
    );
        logic [2*DATA_W-1:0] sh;
        logic [DATA_W-1:0]   v;
        logic                sb;
        sh = cat >> {off, 3'b000};
        v  = sh[DATA_W-1:0];
        sb = 1'b0;
        for (int k = 0; k <= OFF_W; k++)
            if (int'(size) == k) sb = sgn & v[8*(1<<k)-1];
        for (int i = 0; i < BYTES; i++)
            if (i >= (1 << size)) v[8*i +: 8] = {8{sb}};
        return v;
    endfunction

    always_comb begin
        off_in   = bus.req_addr[OFF_W-1:0];
        nb_in    = 1 << bus.req_size;
        err_in   = int'(bus.req_size) > OFF_W;
        cross_in = (int'(off_in) + nb_in) > BYTES;
        mask_in  = '0;
        for (int i = 0; i < 2*BYTES; i++)
            mask_in[i] = (i < nb_in);
        be_lo_w  = mask_in << off_in;
        be_hi_w  = mask_q >> (BYTES - int'(off_q));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            size_q         <= '0;
            sgn_q          <= 1'b0;
            off_q          <= '0;
            cross_q        <= 1'b0;
            mask_q         <= '0;
            wdata_q        <= '0;
            lo_q           <= '0;
            bus.req_ready  <= 1'b1;
            bus.mem_valid  <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_be     <= '0;
            bus.mem_wdata  <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q          <= bus.req_we;
                        size_q        <= bus.req_size;
                        sgn_q         <= bus.req_signed;
                        off_q         <= off_in;
                        cross_q       <= cross_in;
                        mask_q        <= mask_in;
                        wdata_q       <= bus.req_wdata;
                        bus.req_ready <= 1'b0;
                        if (err_in) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= '0;
                        end else begin
                            state         <= BEAT0;
                            bus.mem_valid <= 1'b1;
                            bus.mem_we    <= bus.req_we;
                            bus.mem_addr  <= {bus.req_addr[ADDR_W-1:OFF_W],
                                              {OFF_W{1'b0}}};
                            bus.mem_be    <= be_lo_w[BYTES-1:0];
                            bus.mem_wdata <= bus.req_wdata << {off_in, 3'b000};
                        end
                    end
                end
                BEAT0: begin
                    if (bus.mem_ready) begin
                        lo_q <= bus.mem_rdata;
                        if (cross_q) begin
                            state         <= BEAT1;
                            bus.mem_addr  <= bus.mem_addr + ADDR_W'(BYTES);
                            bus.mem_be    <= be_hi_w[BYTES-1:0];
                            bus.mem_wdata <= wdata_q >> (DATA_W - 8*int'(off_q));
                        end else begin
                            state          <= RESP;
                            bus.mem_valid  <= 1'b0;
                            bus.mem_we     <= 1'b0;
                            bus.mem_addr   <= '0;
                            bus.mem_be     <= '0;
                            bus.mem_wdata  <= '0;
                            bus.resp_valid <= 1'b1;
                            bus.resp_rdata <= we_q ? '0 :
                                extract({{DATA_W{1'b0}}, bus.mem_rdata},
                                        off_q, size_q, sgn_q);
                        end
                    end
                end
                BEAT1: begin
                    if (bus.mem_ready) begin
                        state          <= RESP;
                        bus.mem_valid  <= 1'b0;
                        bus.mem_we     <= 1'b0;
                        bus.mem_addr   <= '0;
                        bus.mem_be     <= '0;
                        bus.mem_wdata  <= '0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= we_q ? '0 :
                            extract({bus.mem_rdata, lo_q},
                                    off_q, size_q, sgn_q);
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state          <= IDLE;
                        bus.resp_valid <= 1'b0;
                        bus.resp_rdata <= '0;
                        bus.resp_err   <= 1'b0;
                        bus.req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdr_align_unit.sv
// Bench for mdr_align_unit (DATA_W = 32): vector table driven through a
// bus model, responses checked against a scoreboard queue.
module tb_mdr_align_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdr_align_unit_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    mdr_align_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] rdata;
        logic        err;
        int          nb;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
    endtask

    task automatic run(input vec_t v, input int mw, input int rw, input string tag);
        int   edges;
        int   beats;
        int   w;
        rsp_t r;
        sb.push_back('{v.rdata, v.err});
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'(1));
        bus.req_valid  = 1'b1;
        bus.req_we     = v.we;
        bus.req_size   = v.size;
        bus.req_signed = v.sgn;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        edges = 1;
        beats = 0;
        w = 0;
        while (!bus.resp_valid && edges < 40) begin
            bus.mem_ready = 1'b0;
            if (bus.mem_valid) begin
                if (beats >= v.nb) begin
                    chk({tag, "_extra_beat"}, 64'(beats), 64'(v.nb));
                end else begin
                    chk({tag, "_mem_we"}, 64'(bus.mem_we), 64'(v.we));
                    chk({tag, "_mem_addr"}, 64'(bus.mem_addr),
                        64'(beats == 0 ? v.a0 : v.a1));
                    chk({tag, "_mem_be"}, 64'(bus.mem_be),
                        64'(beats == 0 ? v.be0 : v.be1));
                    chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata),
                        64'(beats == 0 ? v.wd0 : v.wd1));
                end
                bus.mem_rdata = (beats == 0) ? v.rd0 : v.rd1;
                if (beats > 0 || w >= mw) bus.mem_ready = 1'b1;
                else w++;
            end
            @(posedge clk); #1;
            if (bus.mem_ready) beats++;
            bus.mem_ready = 1'b0;
            edges++;
        end
        chk({tag, "_resp_timeout"}, 64'(bus.resp_valid), 64'(1));
        chk({tag, "_latency"}, 64'(edges), 64'(v.lat + mw));
        chk({tag, "_beats"}, 64'(beats), 64'(v.nb));
        chk({tag, "_resp_mem_idle"},
            {31'b0, bus.mem_valid, bus.mem_be, bus.mem_wdata}, 64'(0));
        for (int i = 0; i < rw; i++) begin
            chk({tag, "_hold_valid"}, 64'(bus.resp_valid), 64'(1));
            chk({tag, "_hold_rdata"}, 64'(bus.resp_rdata), 64'(v.rdata));
            chk({tag, "_hold_ready"}, 64'(bus.req_ready), 64'(0));
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(0), 64'(1));
        end else begin
            r = sb.pop_front();
            chk({tag, "_resp_rdata"}, 64'(bus.resp_rdata), 64'(r.rdata));
            chk({tag, "_resp_err"}, 64'(bus.resp_err), 64'(r.err));
        end
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        chk({tag, "_after_valid"}, 64'(bus.resp_valid), 64'(0));
        chk({tag, "_after_ready"}, 64'(bus.req_ready), 64'(1));
    endtask

    vec_t vt[11];
    vec_t vx;
    int   seen;

    initial begin
        vt[0]  = '{0, 0, 1, 32'h1003, 0, 32'h80123456, 0,
                   32'h1000, 4'b1000, 0, 0, 4'b0000, 0, 32'hFFFFFF80, 0, 1, 2};
        vt[1]  = '{0, 0, 0, 32'h1003, 0, 32'h80123456, 0,
                   32'h1000, 4'b1000, 0, 0, 4'b0000, 0, 32'h00000080, 0, 1, 2};
        vt[2]  = '{0, 1, 1, 32'h1003, 0, 32'hAB000000, 32'h000000CD,
                   32'h1000, 4'b1000, 0, 32'h1004, 4'b0001, 0, 32'hFFFFCDAB, 0, 2, 3};
        vt[3]  = '{1, 2, 0, 32'h2002, 32'h11223344, 0, 0,
                   32'h2000, 4'b1100, 32'h33440000, 32'h2004, 4'b0011,
                   32'h00001122, 0, 0, 2, 3};
        vt[4]  = '{0, 3, 0, 32'h3000, 0, 0, 0,
                   0, 4'b0000, 0, 0, 4'b0000, 0, 0, 1, 0, 1};
        vt[5]  = '{0, 1, 0, 32'hFFFFFFFF, 0, 32'h5A000000, 32'h000000A5,
                   32'hFFFFFFFC, 4'b1000, 0, 32'h0, 4'b0001, 0, 32'h0000A55A, 0, 2, 3};
        vt[6]  = '{0, 2, 1, 32'h4000, 0, 32'h87654321, 0,
                   32'h4000, 4'b1111, 0, 0, 4'b0000, 0, 32'h87654321, 0, 1, 2};
        vt[7]  = '{0, 1, 1, 32'h1002, 0, 32'h7FFF0000, 0,
                   32'h1000, 4'b1100, 0, 0, 4'b0000, 0, 32'h00007FFF, 0, 1, 2};
        vt[8]  = '{1, 0, 0, 32'h5001, 32'hDEADBEEF, 0, 0,
                   32'h5000, 4'b0010, 32'hADBEEF00, 0, 4'b0000, 0, 0, 0, 1, 2};
        vt[9]  = '{0, 1, 1, 32'h1001, 0, 32'h00F08000, 0,
                   32'h1000, 4'b0110, 0, 0, 4'b0000, 0, 32'hFFFFF080, 0, 1, 2};
        vt[10] = '{0, 2, 1, 32'h6001, 0, 32'h33221100, 32'h00000044,
                   32'h6000, 4'b1110, 0, 32'h6004, 4'b0001, 0, 32'h44332211, 0, 2, 3};

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = '0;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = '0;
        bus.resp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
        chk("rst_mem", {31'b0, bus.mem_valid, bus.mem_be, bus.mem_wdata}, 64'(0));
        chk("rst_mem_addr_we", {31'b0, bus.mem_we, bus.mem_addr}, 64'(0));
        chk("rst_resp", {31'b0, bus.resp_valid, bus.resp_err, bus.resp_rdata}, 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++)
            run(vt[i], 0, 0, $sformatf("vec%0d", i));

        run(vt[3], 3, 2, "wait_store");
        run(vt[2], 2, 1, "wait_load");

        vx = vt[2];
        bus.req_valid  = 1'b1;
        bus.req_we     = vx.we;
        bus.req_size   = vx.size;
        bus.req_signed = vx.sgn;
        bus.req_addr   = vx.addr;
        bus.req_wdata  = vx.wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = vx.rd0;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        chk("mid_beat1_valid", 64'(bus.mem_valid), 64'(1));
        chk("mid_beat1_addr", 64'(bus.mem_addr), 64'(32'h1004));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_req_ready", 64'(bus.req_ready), 64'(1));
        chk("mid_rst_mem", {31'b0, bus.mem_valid, bus.mem_be, bus.mem_wdata}, 64'(0));
        chk("mid_rst_addr_we", {31'b0, bus.mem_we, bus.mem_addr}, 64'(0));
        chk("mid_rst_resp",
            {31'b0, bus.resp_valid, bus.resp_err, bus.resp_rdata}, 64'(0));
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid || bus.mem_valid) seen++;
        end
        chk("mid_rst_no_resp", 64'(seen), 64'(0));

        run(vt[0], 0, 0, "post_rst");
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
